cache_cmu: RTL and testbench

//  Cache management unit: the controller that drives the 2-way set-associative cache's control inputs.

---
 rtl/cache_cmu.sv | 201 ++++++++++++++++++++
 tb/tb_cache_cmu.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_cmu.sv
// Cache management unit for a 2-way set-associative cache.
// Forwards CPU accesses to the cache and stalls the CPU on a miss. On a miss it
// writes back a dirty LRU victim word by word, refills the line from memory,
// then re-probes the cache.
module cache_cmu #(
    parameter int ADDR_BITS  = 32,
    parameter int TAG_BITS   = 23,
    parameter int INDEX_BITS = 5,
    parameter int LINE_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [2:0]           req_ubhw,
    input  logic [31:0]          req_wdata,
    output logic [31:0]          rdata,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_edit,
    output logic                 cache_store,
    output logic [2:0]           cache_ubhw,
    output logic [31:0]          cache_din,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    input  logic [31:0]          cache_dout,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack
);

    localparam int WCNT_W = $clog2(LINE_WORDS);
    localparam int IDX_LO = WCNT_W + 2;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, CHECK, BACK_RD, BACK_WR, FILL, REPROBE
    } state_t;

    state_t                state_q, state_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [TAG_BITS-1:0]   vtag_q, vtag_d;
    logic                  mem_cs_q, mem_cs_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  wb_first_q, wb_first_d;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  issue;

    assign req_index = req_addr[IDX_LO +: INDEX_BITS];
    assign req_tag   = req_addr[ADDR_BITS-1 -: TAG_BITS];
    // No cache access may be issued while reset is held.
    assign issue     = req_valid & rst;

    function automatic logic [ADDR_BITS-1:0] line_addr(input logic [TAG_BITS-1:0]   tag,
                                                       input logic [INDEX_BITS-1:0] idx,
                                                       input logic [WCNT_W-1:0]     w);
        return {tag, idx, w, 2'b00};
    endfunction

    assign rdata     = cache_dout;
    assign stall     = req_valid & ~((state_q == CHECK) & cache_hit);
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    // The victim word arrives from the cache in the first BACK_WR cycle; it is
    // forwarded directly then and held in mem_wdata_q for the rest of the write.
    assign mem_wdata = wb_first_q ? cache_dout : mem_wdata_q;

    // Cache-side strobes and address, decoded from the current state.
    always_comb begin
        cache_addr  = req_addr;
        cache_ubhw  = req_ubhw;
        cache_din   = req_wdata;
        cache_load  = 1'b0;
        cache_edit  = 1'b0;
        cache_store = 1'b0;
        case (state_q)
            IDLE, REPROBE: begin
                cache_load = issue & ~req_we;
                cache_edit = issue & req_we;
            end
            BACK_RD, BACK_WR: begin
                cache_addr = line_addr(vtag_q, req_index, wcnt_q);
                cache_ubhw = 3'b010;
            end
            FILL: begin
                cache_addr = mem_addr_q;
                cache_ubhw = 3'b010;
                if (mem_ack) begin
                    cache_store = 1'b1;
                    cache_din   = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Next-state and next-value logic for the miss-handling FSM and memory port.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        vtag_d      = vtag_q;
        mem_cs_d    = mem_cs_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_first_d  = 1'b0;
        case (state_q)
            IDLE, REPROBE: begin
                state_d = req_valid ? CHECK : IDLE;
            end
            CHECK: begin
                if (!req_valid || cache_hit) begin
                    state_d = IDLE;
                end else if (cache_valid && cache_dirty) begin
                    vtag_d  = cache_tag;
                    wcnt_d  = '0;
                    state_d = BACK_RD;
                end else begin
                    wcnt_d     = '0;
                    state_d    = FILL;
                    mem_cs_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = line_addr(req_tag, req_index, '0);
                end
            end
            BACK_RD: begin
                state_d    = BACK_WR;
                wb_first_d = 1'b1;
                mem_cs_d   = 1'b1;
                mem_we_d   = 1'b1;
                mem_addr_d = line_addr(vtag_q, req_index, wcnt_q);
            end
            BACK_WR: begin
                if (wb_first_q) mem_wdata_d = cache_dout;
                if (mem_ack) begin
                    if (wcnt_q == LAST_WORD) begin
                        wcnt_d     = '0;
                        state_d    = FILL;
                        mem_cs_d   = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = line_addr(req_tag, req_index, '0);
                    end else begin
                        wcnt_d   = wcnt_q + 1'b1;
                        state_d  = BACK_RD;
                        mem_cs_d = 1'b0;
                        mem_we_d = 1'b0;
                    end
                end
            end
            FILL: begin
                if (mem_ack) begin
                    if (wcnt_q == LAST_WORD) begin
                        wcnt_d   = '0;
                        state_d  = REPROBE;
                        mem_cs_d = 1'b0;
                    end else begin
                        wcnt_d     = wcnt_q + 1'b1;
                        mem_addr_d = line_addr(req_tag, req_index, wcnt_q + 1'b1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered memory-port outputs; reset abandons any transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            vtag_q      <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_first_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            vtag_q      <= vtag_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_first_q  <= wb_first_d;
        end
    end

endmodule

// File: tb/tb_cache_cmu.sv
// Bench for cache_cmu: behavioural 2-way cache and variable-latency memory,
// directed CPU accesses, and a scoreboard for CPU completions and memory beats.
module tb_cache_cmu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_ubhw;
    logic [31:0] rdata;
    logic        stall;
    logic [31:0] cache_addr;
    logic        cache_load, cache_edit, cache_store;
    logic [2:0]  cache_ubhw;
    logic [31:0] cache_din;
    logic        cache_hit, cache_valid, cache_dirty;
    logic [22:0] cache_tag;
    logic [31:0] cache_dout;
    logic        mem_cs, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    cache_cmu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_ubhw(req_ubhw), .req_wdata(req_wdata),
        .rdata(rdata), .stall(stall),
        .cache_addr(cache_addr), .cache_load(cache_load), .cache_edit(cache_edit),
        .cache_store(cache_store), .cache_ubhw(cache_ubhw), .cache_din(cache_din),
        .cache_hit(cache_hit), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
        .cache_tag(cache_tag), .cache_dout(cache_dout),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct { logic [31:0] data; logic chk_data; int cyc; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } memx_t;
    resp_t rq[$];
    memx_t mq[$];

    int total = 0;
    int bad = 0;
    int lat = 1;
    int n_acks = 0;
    int n_done = 0;
    int n_stores = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0304) ? 32'h8012_3456 : (a ^ 32'hC0DE_0000);
    endfunction

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] u, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (u)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [2:0] u, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        case (u[1:0])
            2'b00:   r[{off, 3'b000} +: 8] = d[7:0];
            2'b01:   r[{off[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    // Behavioural cache: lookup sampled mid-cycle, outputs registered at the next edge.
    logic [22:0] m_tag [2][32];
    logic        m_val [2][32];
    logic        m_dty [2][32];
    logic [31:0] m_dat [2][32][4];
    logic        m_lru [32];

    initial begin : cache_model
        logic [22:0] t;
        logic [4:0]  ix;
        logic [1:0]  wi;
        logic        h, hw, vw, n_hit, n_val, n_dty;
        logic [22:0] n_tag;
        logic [31:0] n_dout;
        cache_hit = 0; cache_valid = 0; cache_dirty = 0; cache_tag = 0; cache_dout = 0;
        for (int s = 0; s < 32; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_tag[w][s] = 0; m_val[w][s] = 0; m_dty[w][s] = 0;
                for (int k = 0; k < 4; k++) m_dat[w][s][k] = 0;
            end
        end
        forever begin
            @(negedge clk);
            n_hit = 0; n_val = 0; n_dty = 0; n_tag = 0; n_dout = 0;
            if (!rst) begin
                for (int s = 0; s < 32; s++) begin
                    m_lru[s] = 0;
                    for (int w = 0; w < 2; w++) begin m_val[w][s] = 0; m_dty[w][s] = 0; end
                end
            end else begin
                t  = cache_addr[31:9];
                ix = cache_addr[8:4];
                wi = cache_addr[3:2];
                hw = m_val[1][ix] && (m_tag[1][ix] == t);
                h  = hw || (m_val[0][ix] && (m_tag[0][ix] == t));
                vw = m_lru[ix];
                n_hit = h; n_val = m_val[vw][ix]; n_dty = m_dty[vw][ix]; n_tag = m_tag[vw][ix];
                n_dout = fmt(h ? m_dat[hw][ix][wi] : m_dat[vw][ix][wi], cache_ubhw, cache_addr[1:0]);
                if (cache_store) begin
                    m_dat[vw][ix][wi] = cache_din;
                    m_tag[vw][ix] = t; m_val[vw][ix] = 1; m_dty[vw][ix] = 0;
                    n_stores++;
                end
                if (cache_edit && h) begin
                    m_dat[hw][ix][wi] = merge(m_dat[hw][ix][wi], cache_din, cache_ubhw, cache_addr[1:0]);
                    m_dty[hw][ix] = 1; m_lru[ix] = ~hw;
                end
                if (cache_load && h) m_lru[ix] = ~hw;
            end
            @(posedge clk); #1;
            cache_hit = n_hit; cache_valid = n_val; cache_dirty = n_dty;
            cache_tag = n_tag; cache_dout = n_dout;
        end
    end

    // Memory: acknowledges each request after lat cycles with a one-cycle pulse.
    initial begin : mem_model
        int cnt;
        cnt = 0; mem_ack = 0; mem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 0;
            if (!rst || !mem_cs) cnt = 0;
            else if (cnt >= lat) begin
                mem_ack = 1; mem_rdata = mem_word(mem_addr); cnt = 0;
            end else cnt++;
        end
    end

    // Scoreboard: CPU completions.
    initial begin : resp_mon
        int busy;
        resp_t e;
        busy = 0;
        forever begin
            @(negedge clk);
            if (rst && req_valid) busy++;
            if (rst && req_valid && !stall) begin
                n_done++;
                if (rq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = rq.pop_front();
                    if (e.chk_data) chk("rdata", rdata, e.data);
                    if (e.cyc >= 0) chk("access_cycles", busy, e.cyc);
                end
                busy = 0;
            end
        end
    end

    // Scoreboard: completed memory beats.
    initial begin : mem_mon
        memx_t e;
        forever begin
            @(negedge clk);
            if (rst && mem_cs && mem_ack) begin
                n_acks++;
                if (mq.size() == 0) chk("unexpected_mem", mem_addr, 32'hFFFF_FFFF);
                else begin
                    e = mq.pop_front();
                    chk("mem_we", mem_we, e.we);
                    chk("mem_addr", mem_addr, e.addr);
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                end
            end
        end
    end

    // Protocol: request held until ack, refill writes only on ack, strobes exclusive.
    initial begin : proto_mon
        logic        p_cs, p_ack;
        logic [31:0] p_addr;
        p_cs = 0; p_ack = 0; p_addr = 0;
        forever begin
            @(negedge clk);
            if (!rst) p_cs = 0;
            else begin
                if (p_cs && !p_ack) chk("mem_hold", {mem_cs, mem_addr}, {1'b1, p_addr});
                if (cache_store)
                    chk("store_beat", {mem_ack, mem_cs, mem_we, cache_ubhw, cache_addr, cache_din},
                        {1'b1, 1'b1, 1'b0, 3'b010, mem_addr, mem_rdata});
                if (cache_load || cache_edit || cache_store)
                    chk("strobe_onehot", $countones({cache_load, cache_edit, cache_store}), 1);
                p_cs = mem_cs; p_ack = mem_ack; p_addr = mem_addr;
            end
        end
    end

    task automatic push_fill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) mq.push_back('{1'b0, base + 32'(4 * i), 32'h0});
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] u,
                         input logic [31:0] wd, input logic [31:0] ed, input logic cd, input int cyc);
        int start, g;
        rq.push_back('{ed, cd, cyc});
        start = n_done;
        req_we = we; req_addr = a; req_ubhw = u; req_wdata = wd; req_valid = 1;
        g = 0;
        while (n_done == start && g < 400) begin @(posedge clk); #1; g++; end
        if (n_done == start) begin
            chk("req_timeout", a, 32'hFFFF_FFFF);
            rq.delete();
        end
        req_valid = 0;
    endtask

    initial begin : stim
        int s0, a0;
        rst = 0; req_valid = 0; req_we = 0; req_addr = 0; req_ubhw = 3'b010; req_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_stall", stall, 0);
        req_valid = 1; #1;
        chk("rst_strobes", {cache_load, cache_edit, cache_store}, 0);
        req_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;

        // Cold load: clean fill, 2+4*(1+1)+2 cycles.
        push_fill(32'h100);
        issue(0, 32'h100, 3'b010, 0, 32'hC0DE_0100, 1, 12);
        issue(0, 32'h100, 3'b010, 0, 32'hC0DE_0100, 1, 2);
        issue(1, 32'h104, 3'b010, 32'hDEAD_BEEF, 0, 0, 2);
        issue(0, 32'h104, 3'b010, 0, 32'hDEAD_BEEF, 1, 2);
        // Same set, other way: clean fill.
        push_fill(32'h2100);
        issue(0, 32'h2104, 3'b010, 0, 32'hC0DE_2104, 1, 12);
        // Third tag evicts the dirty line at 0x100.
        mq.push_back('{1'b1, 32'h100, 32'hC0DE_0100});
        mq.push_back('{1'b1, 32'h104, 32'hDEAD_BEEF});
        mq.push_back('{1'b1, 32'h108, 32'hC0DE_0108});
        mq.push_back('{1'b1, 32'h10C, 32'hC0DE_010C});
        push_fill(32'h4100);
        issue(0, 32'h4104, 3'b010, 0, 32'hC0DE_4104, 1, 24);

        // Slow memory: 5-cycle ack latency, exactly four refill writes.
        lat = 5;
        s0 = n_stores;
        push_fill(32'h6100);
        issue(0, 32'h6108, 3'b010, 0, 32'hC0DE_6108, 1, 28);
        chk("slow_store_count", n_stores - s0, 4);

        // Reset during FILL word 2, then the held request re-fills.
        lat = 3;
        a0 = n_acks;
        mq.push_back('{1'b0, 32'h8200, 32'h0});
        mq.push_back('{1'b0, 32'h8204, 32'h0});
        push_fill(32'h8200);
        fork
            issue(0, 32'h8200, 3'b010, 0, 32'hC0DE_8200, 1, -1);
            begin
                int g;
                g = 0;
                while (n_acks < a0 + 2 && g < 300) begin @(posedge clk); #1; g++; end
                chk("rst_reach_word2", n_acks - a0, 2);
                rst = 0; #1;
                chk("midrst_mem_cs", mem_cs, 0);
                chk("midrst_mem_we", mem_we, 0);
                chk("midrst_mem_addr", mem_addr, 0);
                chk("midrst_store", cache_store, 0);
                repeat (2) @(posedge clk);
                #2 rst = 1;
            end
        join

        // Byte loads with sign and zero extension.
        lat = 1;
        push_fill(32'h300);
        issue(0, 32'h307, 3'b000, 0, 32'hFFFF_FF80, 1, 12);
        issue(0, 32'h307, 3'b100, 0, 32'h0000_0080, 1, 2);

        repeat (6) @(posedge clk);
        #1;
        chk("resp_queue_empty", rq.size(), 0);
        chk("mem_queue_empty", mq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
